fn_truth_table_checker: RTL and testbench
=========================================

# fn_truth_table_checker

Sequencing controller for the three-input logic function block (F = A·B' + B·C, in structural, functional and behavioural forms). It walks the block's inputs through all eight A/B/C combinations and waits a programmable settle time per vector. It then samples the three implementation outputs, compares each against a golden model, and reports pass/fail, an error count and the first failing vector. It sits beside the function block in the lab top level and replaces manual switch-toggling during bring-up.

## Interface
Parameters:
- SETTLE_CYCLES, 1, cycles each vector is held before sampling; legal range 1..255.
- CNT_W, 4, width of the failing-vector counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run.
- f_s  in  1  structural output of the function block.
- f_f  in  1  functional output of the function block.
- f_b  in  1  behavioural output of the function block.
- a_out  out  1  drives input A of the function block.
- b_out  out  1  drives input B.
- c_out  out  1  drives input C.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next start or reset.
- pass  out  1  valid when done=1; 1 if no vector failed.
- err_count  out  CNT_W  number of failing vectors; saturating.
- fail_mask  out  3  sticky per-output failure flags: bit2=f_s, bit1=f_f, bit0=f_b.
- first_fail_vld  out  1  a failing vector has been recorded.
- first_fail_vec  out  3  {A,B,C} of the first failing vector.

## Operation
- Register vec[2:0] drives {a_out,b_out,c_out} = {vec[2],vec[1],vec[0]} at all times.
- Golden model: g = (vec[2] & ~vec[1]) | (vec[1] & vec[0]). Golden is 1 for vec 3, 4, 5 and 7.
- States:
  - IDLE: busy=0, done=0.
  - SETTLE: busy=1. Load cnt=SETTLE_CYCLES-1 on entry; decrement each cycle; leave when cnt=0.
  - CHECK: busy=1. Lasts exactly one cycle.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE or DONE, start=1 → SETTLE. In the same edge: vec←0, err_count←0, fail_mask←0, first_fail_vld←0, first_fail_vec←0.
  - SETTLE, cnt=0 → CHECK.
  - CHECK, vec=7 → DONE.
  - CHECK, vec≠7 → SETTLE with vec←vec+1.
- Actions in CHECK:
  - A vector fails if any of f_s, f_f or f_b differs from g.
  - On failure: err_count increments, saturating at 2^CNT_W−1.
  - fail_mask bits are ORed with the per-output mismatches.
  - If first_fail_vld=0: first_fail_vec←vec and first_fail_vld←1.
- pass = done & (err_count==0). pass is 0 outside DONE.
- start in SETTLE or CHECK is ignored.
- vec holds its last value in DONE (7 on a full run).

## Timing
- Reset values:
  - state=IDLE, vec=0 (a/b/c_out=0).
  - busy=0, done=0, pass=0.
  - err_count=0, fail_mask=0, first_fail_vld=0, first_fail_vec=0.
- Start is accepted at edge 0. busy=1 from cycle 1.
- Each vector takes SETTLE_CYCLES+1 cycles.
- A full run takes 8·(SETTLE_CYCLES+1) cycles. With SETTLE_CYCLES=1, done=1 and busy=0 in cycle 17.
- Failure outputs update on the edge that ends the CHECK cycle, so they are visible the following cycle.
- Reset asserted mid-run takes effect on the next edge and restores all reset values. No partial results are retained.
- err_count saturation: a failure at the maximum count leaves err_count unchanged; fail_mask and first_fail still update.

## Configuration
- STOP_ON_FAIL_EN defined:
  - A CHECK cycle with a failing vector transitions to DONE instead of advancing.
  - vec holds the failing vector; err_count=1.
- STOP_ON_FAIL_EN undefined: all eight vectors are always checked (default).

## Test plan
- Correct function block, SETTLE_CYCLES=1, start pulse:
  - done=1 at cycle 17; pass=1; err_count=0; fail_mask=000; first_fail_vld=0.
- f_f stuck at 0:
  - err_count=4 (vecs 3, 4, 5, 7); fail_mask=010; first_fail_vec=011; pass=0.
- f_b inverted, CNT_W=2:
  - err_count saturates at 3; fail_mask=001; first_fail_vec=000.
- STOP_ON_FAIL_EN defined, f_s stuck at 0:
  - DONE entered after vec 3's CHECK (done=1 at cycle 9); vec=3; err_count=1; fail_mask=100.
- SETTLE_CYCLES=3, start pulses repeated at cycles 5 and 10:
  - Repeated starts are ignored; done=1 at cycle 33.
- rst asserted while vec=4:
  - All outputs return to reset values next cycle.
  - A later start runs the full 16 cycles with clean results.

Source files
------------

// File: rtl/fn_truth_table_checker.sv
// fn_truth_table_checker
// Sequences the three-input function block (F = A&~B | B&C) through all
// eight {A,B,C} vectors. Each vector is held for SETTLE_CYCLES cycles and
// then checked for one cycle. The structural, functional and behavioural
// outputs are each compared against a golden model. Reports pass/fail, a
// saturating error count, per-output sticky failure flags and the first
// failing vector.
// Optional feature: define STOP_ON_FAIL_EN to end the run at the first
// failing vector. That vector is left on a/b/c_out.

module fn_truth_table_checker #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             f_s,
   input  logic             f_f,
   input  logic             f_b,
   output logic             a_out,
   output logic             b_out,
   output logic             c_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [2:0]       fail_mask,
   output logic             first_fail_vld,
   output logic [2:0]       first_fail_vec
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] CHECK  = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [7:0]       CNT_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

   logic [1:0] state;
   logic [2:0] vec;
   logic [7:0] cnt;
   logic       golden;
   logic [2:0] mismatch;
   logic       vec_fail;
   logic       stop_now;

   assign golden   = (vec[2] & ~vec[1]) | (vec[1] & vec[0]);
   assign mismatch = {f_s ^ golden, f_f ^ golden, f_b ^ golden};
   assign vec_fail = |mismatch;

`ifdef STOP_ON_FAIL_EN
   assign stop_now = vec_fail;
`else
   assign stop_now = 1'b0;
`endif

   assign a_out = vec[2];
   assign b_out = vec[1];
   assign c_out = vec[0];
   assign busy  = (state == SETTLE) || (state == CHECK);
   assign done  = (state == DONE);
   assign pass  = done && (err_count == '0);

   // Sequencer FSM plus result bookkeeping; results are cleared when a run starts
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         vec            <= 3'd0;
         cnt            <= 8'd0;
         err_count      <= '0;
         fail_mask      <= 3'b000;
         first_fail_vld <= 1'b0;
         first_fail_vec <= 3'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= SETTLE;
                  cnt            <= CNT_LOAD;
                  vec            <= 3'd0;
                  err_count      <= '0;
                  fail_mask      <= 3'b000;
                  first_fail_vld <= 1'b0;
                  first_fail_vec <= 3'd0;
               end
            end
            SETTLE: begin
               if (cnt == 8'd0) begin
                  state <= CHECK;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            CHECK: begin
               if (vec_fail) begin
                  if (err_count != ERR_MAX) begin
                     err_count <= err_count + CNT_W'(1);
                  end
                  fail_mask <= fail_mask | mismatch;
                  if (!first_fail_vld) begin
                     first_fail_vld <= 1'b1;
                     first_fail_vec <= vec;
                  end
               end
               if ((vec == 3'd7) || stop_now) begin
                  state <= DONE;
               end else begin
                  state <= SETTLE;
                  cnt   <= CNT_LOAD;
                  vec   <= vec + 3'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fn_truth_table_checker.sv
// tb_fn_truth_table_checker
// Drives two checker instances: (SETTLE_CYCLES=1, CNT_W=4) and
// (SETTLE_CYCLES=3, CNT_W=2). Each instance sits beside a modelled function
// block. Each output of that block is the golden value XORed with a
// per-vector fault mask. Expected results come from the masks alone, via
// a per-vector loop over the truth table.

module tb_fn_truth_table_checker;

   logic clk = 1'b0;
   logic rst;
   logic start1, start2;
   logic sel;
   logic [7:0] mask_s, mask_f, mask_b;

   int checks   = 0;
   int failures = 0;

   logic a1, b1, c1, busy1, done1, pass1, ffv1;
   logic [3:0] err1;
   logic [2:0] fm1, ffvec1, v1;
   logic fs1, ff1, fb1;

   logic a2, b2, c2, busy2, done2, pass2, ffv2;
   logic [1:0] err2;
   logic [2:0] fm2, ffvec2, v2;
   logic fs2, ff2, fb2;

   logic o_busy, o_done, o_pass, o_ffv;
   logic [2:0] o_vec, o_fm, o_ffvec;
   logic [31:0] o_err;

   always #5 clk = ~clk;

   function automatic logic gold(input int v);
      return (v == 3) || (v == 4) || (v == 5) || (v == 7);
   endfunction

   assign v1  = {a1, b1, c1};
   assign fs1 = gold(int'(v1)) ^ mask_s[v1];
   assign ff1 = gold(int'(v1)) ^ mask_f[v1];
   assign fb1 = gold(int'(v1)) ^ mask_b[v1];
   assign v2  = {a2, b2, c2};
   assign fs2 = gold(int'(v2)) ^ mask_s[v2];
   assign ff2 = gold(int'(v2)) ^ mask_f[v2];
   assign fb2 = gold(int'(v2)) ^ mask_b[v2];

   assign o_busy  = sel ? busy2 : busy1;
   assign o_done  = sel ? done2 : done1;
   assign o_pass  = sel ? pass2 : pass1;
   assign o_ffv   = sel ? ffv2  : ffv1;
   assign o_vec   = sel ? v2    : v1;
   assign o_fm    = sel ? fm2   : fm1;
   assign o_ffvec = sel ? ffvec2 : ffvec1;
   assign o_err   = sel ? {30'b0, err2} : {28'b0, err1};

   fn_truth_table_checker #(.SETTLE_CYCLES(1), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start1),
      .f_s(fs1), .f_f(ff1), .f_b(fb1),
      .a_out(a1), .b_out(b1), .c_out(c1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_mask(fm1),
      .first_fail_vld(ffv1), .first_fail_vec(ffvec1)
   );

   fn_truth_table_checker #(.SETTLE_CYCLES(3), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .f_s(fs2), .f_f(ff2), .f_b(fb2),
      .a_out(a2), .b_out(b2), .c_out(c2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .fail_mask(fm2),
      .first_fail_vld(ffv2), .first_fail_vec(ffvec2)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic setStart(input logic v);
      if (sel) start2 = v;
      else     start1 = v;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_vec"},   32'(o_vec), 0);
      checkOutput({tag, "_busy"},  32'(o_busy), 0);
      checkOutput({tag, "_done"},  32'(o_done), 0);
      checkOutput({tag, "_pass"},  32'(o_pass), 0);
      checkOutput({tag, "_err"},   o_err, 0);
      checkOutput({tag, "_fmask"}, 32'(o_fm), 0);
      checkOutput({tag, "_ffvld"}, 32'(o_ffv), 0);
      checkOutput({tag, "_ffvec"}, 32'(o_ffvec), 0);
   endtask

   // One full run on the chosen instance, compared against the mask-derived expectation
   task automatic applyStimulus(input string tag, input logic which,
                                input logic [7:0] ms, input logic [7:0] mf, input logic [7:0] mb,
                                input logic rep);
      int settle, maxc, exp_err, nvec, exp_cyc, cyc, last;
      logic [2:0] exp_fm, exp_ffvec, mis;
      logic exp_ffv, stopped;
      settle = which ? 3 : 1;
      maxc   = which ? 3 : 15;
      exp_err = 0; exp_fm = 3'b000; exp_ffv = 1'b0; exp_ffvec = 3'd0;
      last = 7; stopped = 1'b0;
      for (int v = 0; v < 8; v++) begin
         if (!stopped) begin
            mis = {ms[v], mf[v], mb[v]};
            if (mis != 3'b000) begin
               if (exp_err < maxc) exp_err++;
               exp_fm = exp_fm | mis;
               if (!exp_ffv) begin
                  exp_ffv = 1'b1;
                  exp_ffvec = 3'(v);
               end
`ifdef STOP_ON_FAIL_EN
               stopped = 1'b1;
               last = v;
`endif
            end
         end
      end
      nvec    = last + 1;
      exp_cyc = nvec * (settle + 1) + 1;

      sel = which;
      mask_s = ms; mask_f = mf; mask_b = mb;
      @(negedge clk);
      setStart(1'b1);
      @(posedge clk); #1;
      setStart(1'b0);
      cyc = 1;
      checkOutput({tag, "_busy_c1"}, 32'(o_busy), 1);
      while (!o_done && cyc < 200) begin
         if (((cyc - 1) % (settle + 1)) == 0 && cyc < exp_cyc)
            checkOutput({tag, "_vec_seq"}, 32'(o_vec), 32'((cyc - 1) / (settle + 1)));
         setStart(rep && (cyc == 5 || cyc == 10));
         @(posedge clk); #1;
         cyc++;
      end
      setStart(1'b0);
      checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
      checkOutput({tag, "_busy_end"},   32'(o_busy), 0);
      checkOutput({tag, "_pass"},       32'(o_pass), (exp_err == 0) ? 1 : 0);
      checkOutput({tag, "_err"},        o_err, 32'(exp_err));
      checkOutput({tag, "_fmask"},      32'(o_fm), 32'(exp_fm));
      checkOutput({tag, "_ffvld"},      32'(o_ffv), 32'(exp_ffv));
      checkOutput({tag, "_ffvec"},      32'(o_ffvec), 32'(exp_ffvec));
      checkOutput({tag, "_vec_end"},    32'(o_vec), 32'(last));
      @(posedge clk); #1;
      checkOutput({tag, "_done_hold"},  32'(o_done), 1);
   endtask

   // Directed scenarios followed by randomized fault masks
   initial begin
      int  cyc;
      logic [7:0] rm [3];
      rst = 1'b1; start1 = 1'b0; start2 = 1'b0; sel = 1'b0;
      mask_s = 8'h00; mask_f = 8'h00; mask_b = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      sel = 1'b0; checkResetState("reset1");
      sel = 1'b1; checkResetState("reset2");

      $display("[TB] correct block, settle 1");
      applyStimulus("clean", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      $display("[TB] f_f stuck at 0");
      applyStimulus("ff_stuck0", 1'b0, 8'h00, 8'hB8, 8'h00, 1'b0);
      $display("[TB] f_b inverted, CNT_W=2");
      applyStimulus("fb_inv_sat", 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0);
      $display("[TB] f_s stuck at 0");
      applyStimulus("fs_stuck0", 1'b0, 8'hB8, 8'h00, 8'h00, 1'b0);
      $display("[TB] settle 3 with repeated starts");
      applyStimulus("rep_start", 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);

      $display("[TB] reset mid-run");
      sel = 1'b0;
`ifdef STOP_ON_FAIL_EN
      mask_f = 8'h00;
`else
      mask_f = 8'hB8;
`endif
      mask_s = 8'h00; mask_b = 8'h00;
      @(negedge clk); start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      cyc = 0;
      while (o_vec != 3'd4 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("reach_vec4", 32'(o_vec), 4);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      checkResetState("midrun_reset");
      applyStimulus("after_reset", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

      $display("[TB] randomized fault masks");
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 3; k++)
            rm[k] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         applyStimulus("random", 1'($urandom_range(0, 1)), rm[0], rm[1], rm[2], 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
